// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one single-port memory between the
// core fetch path and the program loader, with bounded starvation of fetches.
module imem_arbiter #(
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_req,
  input  logic [31:0]                   fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_rvalid,
  output logic [31:0]                   fetch_rdata,
  output logic                          fetch_err,
  input  logic                          ld_req,
  input  logic [31:0]                   ld_addr,
  input  logic [31:0]                   ld_wdata,
  output logic                          ld_gnt,
  output logic                          ld_err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [$clog2(MEM_BYTES)-3:0]  mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  // Handshake: a request is taken on a rising edge where req && gnt; the
  // requester holds req/addr/data until then, and the response (rvalid or
  // ld_err) appears for exactly the cycle following acceptance.

  logic [CW-1:0] r_starve;
  logic [CW-1:0] w_starve_nxt;
  logic          r_f_vld;
  logic          r_f_err;
  logic          r_ld_err;
  logic          w_fetch_win;
  logic          w_f_ok;
  logic          w_l_ok;

  assign w_f_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr < 32'(MEM_BYTES));
  assign w_l_ok = (ld_addr[1:0] == 2'b00) && (ld_addr < 32'(MEM_BYTES));

  always_comb begin
    w_fetch_win = fetch_req && (!ld_req || (r_starve == LIMIT_C));
    // Grants are gated by rst_n so nothing is accepted while reset is held.
    fetch_gnt   = rst_n && w_fetch_win;
    ld_gnt      = rst_n && ld_req && !w_fetch_win;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (fetch_gnt && w_f_ok) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr[AW-1:2];
    end else if (ld_gnt && w_l_ok) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[AW-1:2];
      mem_wdata = ld_wdata;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (ld_gnt && fetch_req) begin
      if (r_starve != LIMIT_C) w_starve_nxt = r_starve + CW'(1);
    end else if (fetch_gnt || !fetch_req) begin
      w_starve_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
      r_f_vld  <= 1'b0;
      r_f_err  <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_f_vld  <= fetch_gnt;
      r_f_err  <= fetch_gnt && !w_f_ok;
      r_ld_err <= ld_gnt && !w_l_ok;
    end
  end

  assign fetch_rvalid = r_f_vld;
  assign fetch_err    = r_f_err;
  assign ld_err       = r_ld_err;
  // Read data passes straight from the memory, zeroed for errors and idle cycles.
  assign fetch_rdata  = (r_f_vld && !r_f_err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, memory contents and responses.
module tb_imem_arbiter;
  localparam int MEM_BYTES    = 1024;
  localparam int STARVE_LIMIT = 4;
  localparam int NW           = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0] fetch_rdata;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_gnt, ld_err, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_err(ld_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External single-port SRAM, read-first.
  logic [31:0] env_mem [NW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  // Scoreboard and reference model state
  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];     // {err, rdata} of accepted fetches
  logic        exp_l_q[$];   // ld_err of accepted loader writes
  logic [31:0] shadow [NW];
  int          m_starve = 0;
  logic        m_fg, m_lg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < MEM_BYTES);
  endfunction

  task automatic do_cycle(input logic fr, input logic [31:0] fa,
                          input logic lr, input logic [31:0] la, input logic [31:0] lw);
    logic [32:0] e;
    logic        el, e_en, e_we;
    logic [31:0] e_addr, e_wdata;
    int          fi, li;
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa; ld_req = lr; ld_addr = la; ld_wdata = lw;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fetch_rvalid", 32'(fetch_rvalid), 32'd1);
      check("fetch_err", 32'(fetch_err), 32'(e[32]));
      check("fetch_rdata", fetch_rdata, e[31:0]);
    end else begin
      check("fetch_rvalid_idle", 32'(fetch_rvalid), 32'd0);
    end
    el = (exp_l_q.size() > 0) ? exp_l_q.pop_front() : 1'b0;
    check("ld_err", 32'(ld_err), 32'(el));

    m_fg = fr && (!lr || m_starve >= STARVE_LIMIT);
    m_lg = lr && !m_fg;
    check("fetch_gnt", 32'(fetch_gnt), 32'(m_fg));
    check("ld_gnt", 32'(ld_gnt), 32'(m_lg));
    fi = int'(fa / 4) % NW;
    li = int'(la / 4) % NW;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (m_fg && addr_ok(fa)) begin
      e_en = 1'b1; e_addr = 32'(fi);
    end else if (m_lg && addr_ok(la)) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = 32'(li); e_wdata = lw;
    end
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) check("mem_addr", 32'(mem_addr), e_addr);
    if (e_we || !e_en) check("mem_wdata", mem_wdata, e_wdata);

    if (m_fg) exp_q.push_back(addr_ok(fa) ? {1'b0, shadow[fi]} : {1'b1, 32'h0});
    if (m_lg) begin
      exp_l_q.push_back(!addr_ok(la));
      if (addr_ok(la)) shadow[li] = lw;
    end
    if (fr && m_lg) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    else            m_starve = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [5:0]  pat;
  logic        h_fr, h_lr;
  logic [31:0] h_fa, h_la, h_lw;

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
    if (k == 1) return 32'(MEM_BYTES) + 32'($urandom_range(0, 63)) * 4;
    return 32'($urandom_range(0, 31)) * 4;
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin
      shadow[i]  = $urandom;
      env_mem[i] = shadow[i];
    end
    shadow[0] = 32'h00000013; env_mem[0] = 32'h00000013;
    shadow[1] = 32'h00100093; env_mem[1] = 32'h00100093;
    shadow[2] = 32'h00200113; env_mem[2] = 32'h00200113;

    // Reset holds everything quiet even with requests pending
    fetch_req = 1'b1; ld_req = 1'b1; ld_addr = 32'h20;
    #12;
    check("rst_gnt_f", 32'(fetch_gnt), 32'd0);
    check("rst_gnt_l", 32'(ld_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rvalid", 32'(fetch_rvalid), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_rdata", fetch_rdata, 32'd0);
    @(negedge clk);
    fetch_req = 1'b0; ld_req = 1'b0; rst_n = 1'b1;
    idle(1);

    // Back-to-back fetches
    do_cycle(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    idle(2);

    // Contention with starvation relief
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 32'h20, 1'b1, 32'h100 + 32'(i) * 4, $urandom);
      pat[i] = ld_gnt;
    end
    check("contention_pattern", 32'(pat), 32'h2f);
    idle(2);

    // Error paths
    do_cycle(1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    do_cycle(1'b0, 32'h0, 1'b1, 32'h400, 32'h12345678);
    do_cycle(1'b1, 32'hfffffffc, 1'b1, 32'h3, 32'h1);
    idle(3);

    // Write then immediate read of the same word
    do_cycle(1'b0, 32'h0, 1'b1, 32'h10, 32'hdeadbeef);
    do_cycle(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    idle(1);

    // Asynchronous reset the cycle after a fetch grant
    do_cycle(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_rvalid", 32'(fetch_rvalid), 32'd0);
    check("arst_rdata", fetch_rdata, 32'd0);
    check("arst_ld_err", 32'(ld_err), 32'd0);
    exp_q.delete(); exp_l_q.delete(); m_starve = 0;
    fetch_req = 1'b1; ld_req = 1'b1;
    #1;
    check("arst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    fetch_req = 1'b0; ld_req = 1'b0; rst_n = 1'b1;
    idle(2);
    do_cycle(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    idle(1);

    // Randomized traffic; an ungranted request is held unchanged
    h_fr = 1'b0; h_lr = 1'b0; h_fa = '0; h_la = '0; h_lw = '0;
    for (int n = 0; n < 500; n++) begin
      if (!(h_fr && !m_fg)) begin
        h_fr = ($urandom_range(0, 3) != 0);
        h_fa = rand_addr();
      end
      if (!(h_lr && !m_lg)) begin
        h_lr = ($urandom_range(0, 2) != 0);
        h_la = rand_addr();
        h_lw = $urandom;
      end
      do_cycle(h_fr, h_fa, h_lr, h_la, h_lw);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
